// File: rtl/syscall_display_buffer_pkg.sv
// Shared definitions for the syscall display buffer: display width, FSM encoding
// and the width helper used for the occupancy count.
package syscall_display_buffer_pkg;

  localparam int DISPLAY_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_e;

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/syscall_display_buffer_if.sv
// CPU-facing push port and LED-facing display port of the syscall display buffer.
interface syscall_display_buffer_if
  import syscall_display_buffer_pkg::*;
#(
  parameter int DATA_W = DISPLAY_W,
  parameter int DEPTH  = 8
) ();

  localparam int CNT_W = count_width(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DATA_W-1:0] display_data;
  logic              showing;

  modport master (
    output wr_en, wr_data,
    input  full, count, overflow, display_data, showing
  );

  modport slave (
    input  wr_en, wr_data,
    output full, count, overflow, display_data, showing
  );

endinterface

// File: rtl/syscall_display_buffer_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from the count
// so wrapping pointers never need an extra lap bit.
module syscall_display_buffer_sync_fifo
  import syscall_display_buffer_pkg::*;
#(
  parameter int DATA_W = DISPLAY_W,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [DATA_W-1:0]            i_data,
  output logic [DATA_W-1:0]            o_head,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Storage needs no reset: a zero count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/syscall_display_buffer.sv
// Queues syscall display values from the cpu and shows each one on the LED display
// for HOLD_CYCLES clocks, back-pressuring the cpu through full.
module syscall_display_buffer
  import syscall_display_buffer_pkg::*;
#(
  parameter int DATA_W      = DISPLAY_W,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  syscall_display_buffer_if.slave bus
);

  localparam int CNT_W  = count_width(DEPTH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  disp_state_e       r_state;
  disp_state_e       w_nextState;
  logic [HOLD_W-1:0] r_hold;
  logic [DATA_W-1:0] r_display;
  logic              r_overflow;
  logic              w_pop;
  logic              w_showing;
  logic              w_holdDone;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;

  syscall_display_buffer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.wr_en),
    .i_pop   (w_pop),
    .i_data  (bus.wr_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_holdDone = (r_hold == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_nextState = SHOW;
      SHOW:    if (w_holdDone && w_empty) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_showing = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = !w_empty;
      end
      SHOW: begin
        w_showing = 1'b1;
        w_pop     = w_holdDone && !w_empty;
      end
      default: begin
        w_pop     = 1'b0;
        w_showing = 1'b0;
      end
    endcase
  end

  // A pop always restarts the hold window; otherwise count down to zero and stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_display <= '0;
      r_hold    <= '0;
    end else if (w_pop) begin
      r_display <= w_head;
      r_hold    <= HOLD_RELOAD;
    end else if (r_state == SHOW && !w_holdDone) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  // full is the registered status, so a same-cycle pop does not rescue the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.full         = w_full;
  assign bus.count        = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.display_data = r_display;
  assign bus.showing      = w_showing;

endmodule

// File: tb/tb_syscall_display_buffer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random
// traffic, all compared against a queue-based model of the display buffer.
module tb_syscall_display_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 4;

  typedef struct {
    bit          wrEn;
    logic [31:0] wrData;
    int          expCount;
    bit          expShowing;
    logic [31:0] expDisplay;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelQ[$];
  logic [31:0] modelDisp;
  int          modelRemaining;
  bit          modelOverflow;
  logic [31:0] seen[$];
  int          showCycles;
  int          hits;

  syscall_display_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  syscall_display_buffer #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelDisp      = '0;
    modelRemaining = 0;
    modelOverflow  = 1'b0;
  endtask

  // remaining = clocks still to be shown, counting the current one.
  task automatic modelStep(input bit wrEn, input logic [31:0] data);
    bit wasFull;
    wasFull = (modelQ.size() == DEPTH);
    if (modelQ.size() != 0 && modelRemaining <= 1) begin
      modelDisp      = modelQ.pop_front();
      modelRemaining = HOLD;
    end else if (modelRemaining > 0) begin
      modelRemaining--;
    end
    if (wrEn) begin
      if (wasFull) modelOverflow = 1'b1;
      else modelQ.push_back(data);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".count"}, 32'(bus.count), 32'(modelQ.size()));
    checkValue({tag, ".full"}, 32'(bus.full), 32'(modelQ.size() == DEPTH));
    checkValue({tag, ".overflow"}, 32'(bus.overflow), 32'(modelOverflow));
    checkValue({tag, ".display"}, bus.display_data, modelDisp);
    checkValue({tag, ".showing"}, 32'(bus.showing), 32'(modelRemaining > 0));
  endtask

  task automatic applyStimulus(input bit wrEn, input logic [31:0] data, input string tag);
    bus.wr_en   = wrEn;
    bus.wr_data = data;
    @(posedge clk);
    modelStep(wrEn, data);
    #1;
    bus.wr_en = 1'b0;
    checkOutput(tag);
    if (bus.showing && (seen.size() == 0 || seen[$] !== bus.display_data))
      seen.push_back(bus.display_data);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 32'h1, 1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h2, 1, 1'b1, 32'h1};
    vecs[2]  = '{1'b1, 32'h3, 2, 1'b1, 32'h1};
    vecs[3]  = '{1'b0, 32'h0, 2, 1'b1, 32'h1};
    vecs[4]  = '{1'b0, 32'h0, 2, 1'b1, 32'h1};
    vecs[5]  = '{1'b0, 32'h0, 1, 1'b1, 32'h2};
    vecs[6]  = '{1'b0, 32'h0, 1, 1'b1, 32'h2};
    vecs[7]  = '{1'b0, 32'h0, 1, 1'b1, 32'h2};
    vecs[8]  = '{1'b0, 32'h0, 1, 1'b1, 32'h2};
    vecs[9]  = '{1'b0, 32'h0, 0, 1'b1, 32'h3};
    vecs[10] = '{1'b0, 32'h0, 0, 1'b1, 32'h3};
    vecs[11] = '{1'b0, 32'h0, 0, 1'b1, 32'h3};
    vecs[12] = '{1'b0, 32'h0, 0, 1'b1, 32'h3};
    vecs[13] = '{1'b0, 32'h0, 0, 1'b0, 32'h3};
    vecs[14] = '{1'b0, 32'h0, 0, 1'b0, 32'h3};

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    modelReset();
    #1;
    checkOutput("reset");
    doReset();

    $display("[TB] single write");
    applyStimulus(1'b1, 32'hDEADBEEF, "t2");
    checkValue("t2.notYet", bus.display_data, 32'h0);
    applyStimulus(1'b0, 32'h0, "t2");
    checkValue("t2.display", bus.display_data, 32'hDEADBEEF);
    showCycles = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0, "t2");
      if (bus.showing) showCycles++;
    end
    checkValue("t2.holdLen", 32'(showCycles), 32'(HOLD));
    checkValue("t2.retained", bus.display_data, 32'hDEADBEEF);

    $display("[TB] burst table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].wrEn, vecs[i].wrData, "t3");
      checkValue($sformatf("t3.vec%0d.count", i), 32'(bus.count), 32'(vecs[i].expCount));
      checkValue($sformatf("t3.vec%0d.showing", i), 32'(bus.showing), 32'(vecs[i].expShowing));
      checkValue($sformatf("t3.vec%0d.display", i), bus.display_data, vecs[i].expDisplay);
    end

    $display("[TB] fill and overflow");
    seen.delete();
    applyStimulus(1'b1, 32'hA0, "t4");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), "t4");
    checkValue("t4.fullAtFour", 32'(bus.full), 32'h1);
    checkValue("t4.countFour", 32'(bus.count), 32'h4);
    checkValue("t4.noOverflowYet", 32'(bus.overflow), 32'h0);
    applyStimulus(1'b1, 32'hA5, "t5");
    checkValue("t5.dropOverflow", 32'(bus.overflow), 32'h1);
    checkValue("t5.countThree", 32'(bus.count), 32'h3);
    checkValue("t5.notFull", 32'(bus.full), 32'h0);
    repeat (4) applyStimulus(1'b0, 32'h0, "t4");
    checkValue("t4.countTwo", 32'(bus.count), 32'h2);
    checkValue("t4.stickyOverflow", 32'(bus.overflow), 32'h1);
    repeat (16) applyStimulus(1'b0, 32'h0, "t4");
    hits = 0;
    foreach (seen[i]) if (seen[i] == 32'hA5) hits++;
    checkValue("t4.droppedNeverShown", 32'(hits), 32'h0);
    checkValue("t4.shownCount", 32'(seen.size()), 32'h5);
    for (int i = 0; i < seen.size() && i < 5; i++)
      checkValue($sformatf("t4.order%0d", i), seen[i], 32'hA0 + 32'(i));
    checkValue("t4.stickyAfterDrain", 32'(bus.overflow), 32'h1);

    $display("[TB] reset mid-hold");
    applyStimulus(1'b1, 32'hB0, "t1");
    applyStimulus(1'b1, 32'hB1, "t1");
    applyStimulus(1'b1, 32'hB2, "t1");
    checkValue("t1.queuedTwo", 32'(bus.count), 32'h2);
    checkValue("t1.showingBefore", 32'(bus.showing), 32'h1);
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkValue("t1.countZero", 32'(bus.count), 32'h0);
    checkValue("t1.displayZero", bus.display_data, 32'h0);
    checkValue("t1.showingZero", 32'(bus.showing), 32'h0);
    checkValue("t1.overflowZero", 32'(bus.overflow), 32'h0);
    checkValue("t1.fullZero", 32'(bus.full), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) applyStimulus(1'b0, 32'h0, "t1");
    checkValue("t1.displayAfterRelease", bus.display_data, 32'h0);

    $display("[TB] pointer wrap");
    seen.delete();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), "t6");
      repeat (3 + (i % 3)) applyStimulus(1'b0, 32'h0, "t6");
    end
    repeat (30) applyStimulus(1'b0, 32'h0, "t6");
    checkValue("t6.shownCount", 32'(seen.size()), 32'd12);
    for (int i = 0; i < seen.size() && i < 12; i++)
      checkValue($sformatf("t6.order%0d", i), seen[i], 32'h100 + 32'(i));
    checkValue("t6.noOverflow", 32'(bus.overflow), 32'h0);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom, "rand");
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 1) == 0, $urandom, "randDense");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
